// File: rtl/sd_dat_seq.sv
// DAT-line transfer sequencer: schedules block reads/writes and busy waits, tracks the
// remaining block count, and drives Auto CMD12/CMD23 requests and block-gap control.
module sd_dat_seq #(
   parameter int unsigned BLK_CNT_W  = 32,
   parameter bit          AUTO_CMD23 = 1'b1,
   parameter bit          READ_WAIT  = 1'b1
) (
   input  logic                 sdclk_i,
   input  logic                 rst_dat_ni,
   input  logic                 cmd_go_i,
   output logic                 main_cmd_go_o,
   input  logic                 command_end_i,
   input  logic                 command_complete_i,
   input  logic                 data_present_i,
   input  logic                 transfer_direction_i,
   input  logic                 multi_block_i,
   input  logic                 block_count_enable_i,
   input  logic [1:0]           response_type_i,
   input  logic [1:0]           command_type_i,
   input  logic [1:0]           auto_cmd_mode_i,
   input  logic [BLK_CNT_W-1:0] block_count_i,
   input  logic                 gap_stop_i,
   input  logic                 gap_continue_i,
   input  logic                 read_wait_en_i,
   input  logic                 r_buf_full_i,
   input  logic                 w_buf_empty_i,
   input  logic                 sd_resumed_i,
   input  logic                 xfer_done_i,
   input  logic                 xfer_crc_err_i,
   input  logic                 xfer_end_err_i,
   input  logic                 xfer_tout_err_i,
   input  logic                 auto_cmd_complete_i,
   input  logic                 auto_cmd_error_i,
   output logic                 issue_read_o,
   output logic                 issue_write_o,
   output logic                 issue_busy_o,
   output logic                 r_reset_o,
   output logic                 w_reset_o,
   output logic                 auto_cmd12_issue_o,
   output logic                 auto_cmd23_issue_o,
   output logic                 pause_req_o,
   output logic                 read_wait_o,
   output logic                 block_gap_o,
   output logic [BLK_CNT_W-1:0] block_count_o,
   output logic                 read_xfer_active_o,
   output logic                 write_xfer_active_o,
   output logic                 dat_line_active_o,
   output logic                 transfer_complete_o,
   output logic                 data_crc_error_o,
   output logic                 data_end_bit_error_o,
   output logic                 data_timeout_error_o,
   output logic                 auto_cmd_error_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE23, S_OP, S_COMP, S_RD_HOLD,
      S_WR_GAP, S_WR_BUF, S_BUSY, S_POST12, S_ERROR
   } state_t;

   localparam logic [BLK_CNT_W-1:0] ONE = {{(BLK_CNT_W-1){1'b0}}, 1'b1};

   state_t               r_state, w_state_d;
   logic [BLK_CNT_W-1:0] r_cnt, w_cnt_d;
   logic                 r_rd_act, r_wr_act, r_line_act;
   logic                 w_rd_act_d, w_wr_act_d, w_line_act_d;
   logic                 r_zero_blk, w_zero_blk_d;
   logic                 r_gap_req, w_gap_req_d;
   logic                 r_rw_mode, w_rw_mode_d;
   logic                 w_abort, w_acmd23, w_acmd12, w_rw_en, w_xfer_err;

   assign w_abort    = command_end_i && (command_type_i == 2'b11);
   assign w_acmd23   = AUTO_CMD23 && (auto_cmd_mode_i == 2'b10);
   assign w_acmd12   = (auto_cmd_mode_i == 2'b01);
   assign w_rw_en    = READ_WAIT && read_wait_en_i;
   assign w_xfer_err = xfer_crc_err_i || xfer_end_err_i || xfer_tout_err_i;

   always_comb begin
      w_state_d            = r_state;
      w_cnt_d              = r_cnt;
      w_rd_act_d           = r_rd_act;
      w_wr_act_d           = r_wr_act;
      w_line_act_d         = r_line_act;
      w_zero_blk_d         = 1'b0;
      w_gap_req_d          = r_gap_req;
      w_rw_mode_d          = r_rw_mode;
      main_cmd_go_o        = 1'b0;
      issue_read_o         = 1'b0;
      issue_write_o        = 1'b0;
      issue_busy_o         = 1'b0;
      r_reset_o            = 1'b0;
      w_reset_o            = 1'b0;
      auto_cmd12_issue_o   = 1'b0;
      auto_cmd23_issue_o   = 1'b0;
      pause_req_o          = 1'b0;
      read_wait_o          = 1'b0;
      block_gap_o          = 1'b0;
      data_crc_error_o     = 1'b0;
      data_end_bit_error_o = 1'b0;
      data_timeout_error_o = 1'b0;
      auto_cmd_error_o     = 1'b0;

      // Reset gates every pulse; an abort wins over all state-specific behaviour.
      if (!rst_dat_ni) begin
         w_state_d = S_IDLE;
      end else if (w_abort) begin
         w_state_d = S_ERROR;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (command_end_i && data_present_i) begin
                  w_cnt_d = multi_block_i ? (block_count_enable_i ? block_count_i : '0) : ONE;
                  if (multi_block_i && block_count_enable_i && (block_count_i == '0)) begin
                     w_zero_blk_d = 1'b1;
                  end else if (transfer_direction_i) begin
                     w_rd_act_d   = 1'b1;
                     w_line_act_d = 1'b1;
                     r_reset_o    = 1'b1;
                     issue_read_o = 1'b1;
                     w_state_d    = S_OP;
                  end else begin
                     w_wr_act_d   = 1'b1;
                     w_line_act_d = 1'b1;
                     w_reset_o    = 1'b1;
                  end
               end else if (command_complete_i) begin
                  if (response_type_i == 2'b11) begin
                     w_line_act_d = 1'b1;
                     issue_busy_o = 1'b1;
                     w_state_d    = S_BUSY;
                  end else if (r_wr_act) begin
                     w_state_d = S_WR_BUF;
                  end
               end else if (cmd_go_i) begin
                  if (w_acmd23 && data_present_i) begin
                     auto_cmd23_issue_o = 1'b1;
                     w_state_d          = S_PRE23;
                  end else begin
                     main_cmd_go_o = 1'b1;
                  end
               end
            end
            S_PRE23: begin
               if (auto_cmd_complete_i) begin
                  main_cmd_go_o = 1'b1;
                  w_state_d     = S_IDLE;
               end else if (auto_cmd_error_i) begin
                  auto_cmd_error_o = 1'b1;
                  w_state_d        = S_ERROR;
               end
            end
            S_OP: begin
               if (xfer_done_i) begin
                  if (w_xfer_err) begin
                     data_crc_error_o     = xfer_crc_err_i;
                     data_end_bit_error_o = xfer_end_err_i;
                     data_timeout_error_o = xfer_tout_err_i;
                     w_state_d            = S_ERROR;
                  end else begin
                     if (r_cnt != '0) w_cnt_d = r_cnt - ONE;
                     if (r_cnt == ONE) begin
                        if (w_acmd12) begin
                           auto_cmd12_issue_o = 1'b1;
                           w_state_d          = S_POST12;
                        end else begin
                           w_rd_act_d   = 1'b0;
                           w_wr_act_d   = 1'b0;
                           w_line_act_d = 1'b0;
                           w_state_d    = S_IDLE;
                        end
                     end else begin
                        w_state_d = S_COMP;
                     end
                  end
               end
            end
            S_COMP: begin
               if (gap_stop_i) begin
                  w_rd_act_d   = 1'b0;
                  w_wr_act_d   = 1'b0;
                  w_line_act_d = 1'b0;
                  block_gap_o  = 1'b1;
               end
               if (transfer_direction_i) begin
                  if (r_buf_full_i || gap_stop_i) begin
                     w_gap_req_d = gap_stop_i;
                     w_rw_mode_d = w_rw_en;
                     pause_req_o = !w_rw_en;
                     w_state_d   = S_RD_HOLD;
                  end else begin
                     issue_read_o = 1'b1;
                     w_state_d    = S_OP;
                  end
               end else begin
                  w_state_d = gap_stop_i ? S_WR_GAP : S_WR_BUF;
               end
            end
            S_RD_HOLD: begin
               read_wait_o = r_rw_mode;
               if (r_rw_mode ? (!r_buf_full_i && (!r_gap_req || gap_continue_i)) : sd_resumed_i) begin
                  w_rd_act_d   = 1'b1;
                  w_line_act_d = 1'b1;
                  issue_read_o = 1'b1;
                  w_state_d    = S_OP;
               end
            end
            S_WR_GAP: begin
               if (gap_continue_i) begin
                  w_wr_act_d   = 1'b1;
                  w_line_act_d = 1'b1;
                  w_state_d    = S_WR_BUF;
               end
            end
            S_WR_BUF: begin
               if (!w_buf_empty_i) begin
                  issue_write_o = 1'b1;
                  w_state_d     = S_OP;
               end
            end
            S_POST12: begin
               if (auto_cmd_complete_i) begin
                  issue_busy_o = 1'b1;
                  w_state_d    = S_BUSY;
               end else if (auto_cmd_error_i) begin
                  auto_cmd_error_o = 1'b1;
                  w_state_d        = S_ERROR;
               end
            end
            S_BUSY: begin
               if (xfer_done_i) begin
                  data_timeout_error_o = xfer_tout_err_i;
                  w_rd_act_d           = 1'b0;
                  w_wr_act_d           = 1'b0;
                  w_line_act_d         = 1'b0;
                  w_state_d            = S_IDLE;
               end
            end
            default: begin
               w_state_d = S_ERROR;
            end
         endcase
      end

      transfer_complete_o = rst_dat_ni &&
                            (((r_state != S_IDLE) && (w_state_d == S_IDLE)) || (r_zero_blk && !w_abort));
   end

   always_ff @(posedge sdclk_i or negedge rst_dat_ni) begin
      if (!rst_dat_ni) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rd_act   <= 1'b0;
         r_wr_act   <= 1'b0;
         r_line_act <= 1'b0;
         r_zero_blk <= 1'b0;
         r_gap_req  <= 1'b0;
         r_rw_mode  <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_rd_act   <= w_rd_act_d;
         r_wr_act   <= w_wr_act_d;
         r_line_act <= w_line_act_d;
         r_zero_blk <= w_zero_blk_d;
         r_gap_req  <= w_gap_req_d;
         r_rw_mode  <= w_rw_mode_d;
      end
   end

   assign block_count_o       = r_cnt;
   assign read_xfer_active_o  = r_rd_act;
   assign write_xfer_active_o = r_wr_act;
   assign dat_line_active_o   = r_line_act;

endmodule
